rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
- Arbitrates the register file's single write port between two requesters:
  - the pipeline writeback stage (WB), the primary requester;
  - the multi-cycle mul/div unit (MDU), whose results arrive asynchronously to the pipeline.
- Buffers MDU results in a small FIFO until a free write slot exists.
- Keeps a per-register busy scoreboard so ID can stall on operands with an outstanding MDU write.
- Sits between WB/MDU and the register file write port (wr/addr3/data3).

Parameters:
- DEPTH, 2, MDU result FIFO entries; legal range 1..4.
- STARVE_LIMIT, 4, cycles a FIFO head may wait before WB is forced to yield; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wb_wr  in  1  WB write request.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- wb_stall  out  1  WB not granted this cycle; WB must hold and re-present the same request next cycle.
- mdu_issue  in  1  MDU op issued; marks its destination busy.
- mdu_issue_addr  in  5  destination of the issued MDU op.
- issue_ok  out  1  high when busy[mdu_issue_addr]==0.
- mdu_valid  in  1  MDU result available.
- mdu_addr  in  5  MDU result destination.
- mdu_data  in  32  MDU result data.
- mdu_ready  out  1  FIFO can accept a result (count<DEPTH).
- rf_wr  out  1  to register file wr.
- rf_addr  out  5  to register file addr3.
- rf_data  out  32  to register file data3.
- chk_addr1  in  5  ID operand 1 lookup address.
- chk_addr2  in  5  ID operand 2 lookup address.
- chk_busy1  out  1  busy[chk_addr1]; 0 when chk_addr1==0.
- chk_busy2  out  1  busy[chk_addr2]; 0 when chk_addr2==0.
- fifo_count  out  3  current FIFO occupancy.
- proto_err  out  1  sticky; set on any protocol violation listed below.

Behaviour:
Reset
- While reset=1 at posedge: FIFO emptied, all busy bits cleared, starve counter=0, proto_err=0.
- Resulting outputs: fifo_count=0, mdu_ready=1, rf_wr=0, wb_stall=0, chk_busy*=0.
- Reset asserted mid-operation discards buffered results with no write.

Grant (combinational, same cycle)
- force = fifo non-empty && starve_cnt==STARVE_LIMIT.
- If force: FIFO head drives the port and wb_stall=wb_wr.
- Else if wb_wr: WB drives the port (zero latency) and wb_stall=0.
- Else if FIFO non-empty: FIFO head drives the port.
- Else: rf_wr=0.
- rf_wr is never asserted for address 0.

FIFO
- Enqueue on mdu_valid && mdu_ready.
- Dequeue when the head is granted.
- Enqueue and dequeue in the same cycle keep the count unchanged.
- No bypass: an accepted result is written no earlier than the next cycle.
- mdu_ready depends only on the registered count, so a full FIFO does not accept even if it drains in that cycle.
- An entry with addr 0 is enqueued and granted normally, but no write and no scoreboard effect occur.
- Entries are written in acceptance order.

Starvation counter
- Increments each cycle the FIFO is non-empty and the head is not granted.
- Resets to 0 when the head is granted or the FIFO is empty.
- Saturates at STARVE_LIMIT.

Scoreboard
- busy[r] is set at posedge on mdu_issue && mdu_issue_addr!=0.
- busy[r] is cleared at posedge when a FIFO entry with addr r is granted.
- Set and clear for the same r in the same cycle: set wins.
- chk_busy* and issue_ok read the registered busy values; there is no same-cycle forwarding.

Protocol errors (set proto_err)
- mdu_issue with issue_ok=0.
- Accepted mdu_valid whose addr is non-zero and not busy.
- Granted WB write to a register that is busy (WAW).
- mdu_valid while mdu_ready=0; the result is not accepted.

Test Plan:
1. Reset then idle; wb_wr=1, addr=5, data=0x1234 -> same cycle rf_wr=1, rf_addr=5, rf_data=0x1234, wb_stall=0; reset=1 mid-stream -> rf_wr=0 and fifo_count=0 the next cycle.
2. mdu_issue addr 7; next cycle chk_addr1=7 -> chk_busy1=1; mdu_valid addr 7, data 0xDEAD with WB idle -> accepted, fifo_count=1, written the following cycle, then chk_busy1=0.
3. DEPTH=2: issue r8 and r9, push both results while WB writes every cycle -> mdu_ready=0 at count 2. A third mdu_valid -> proto_err=1, result not accepted.
4. STARVE_LIMIT=4 with continuous wb_wr and one buffered result -> head waits 4 cycles, then on the 5th cycle wb_stall=1, the FIFO head is written, starve_cnt returns to 0, and the held WB request is written the next cycle.
5. mdu_issue r3 in the same cycle the FIFO head for r3 drains -> busy[3]=1 after the edge. WB write to r3 while busy -> proto_err=1, write still performed.
6. mdu_valid to addr 0 and wb_wr to addr 0 -> rf_wr stays 0, scoreboard unchanged, proto_err stays 0.

Source files
------------

// File: rtl/rf_wport_arbiter_if.sv
// Bundle of WB, MDU, ID lookup and register file write port signals
// seen by the write-port arbiter.
interface rf_wport_arbiter_if;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        issue_ok;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic [2:0]  fifo_count;
    logic        proto_err;

    modport master (
        output wb_wr, wb_addr, wb_data,
        output mdu_issue, mdu_issue_addr,
        output mdu_valid, mdu_addr, mdu_data,
        output chk_addr1, chk_addr2,
        input  wb_stall, issue_ok, mdu_ready,
        input  rf_wr, rf_addr, rf_data,
        input  chk_busy1, chk_busy2,
        input  fifo_count, proto_err
    );

    modport slave (
        input  wb_wr, wb_addr, wb_data,
        input  mdu_issue, mdu_issue_addr,
        input  mdu_valid, mdu_addr, mdu_data,
        input  chk_addr1, chk_addr2,
        output wb_stall, issue_ok, mdu_ready,
        output rf_wr, rf_addr, rf_data,
        output chk_busy1, chk_busy2,
        output fifo_count, proto_err
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register file write-port arbiter: WB has priority, MDU results are
// buffered in a FIFO, with starvation forcing and a busy scoreboard.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic reset,
    rf_wport_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [2:0] DEP = 3'(DEPTH);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    starve_q, starve_d;
    logic [31:0]   busy_q, busy_d;
    logic          perr_q, perr_d;

    logic        empty;
    logic        force_h;
    logic        ready;
    logic        push;
    logic        pop;
    logic        grant_wb;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign empty     = (cnt_q == 3'd0);
    assign ready     = (cnt_q < DEP);
    assign head_addr = addr_q[rd_q];
    assign head_data = data_q[rd_q];
    assign force_h   = !empty && (starve_q == LIM);
    assign pop       = !empty && (force_h || !bus.wb_wr);
    assign grant_wb  = bus.wb_wr && !force_h;
    assign push      = bus.mdu_valid && ready;

    assign bus.mdu_ready  = ready;
    assign bus.wb_stall   = bus.wb_wr && force_h;
    assign bus.fifo_count = cnt_q;
    assign bus.proto_err  = perr_q;
    assign bus.issue_ok   = !busy_q[bus.mdu_issue_addr];
    assign bus.chk_busy1  = (bus.chk_addr1 != 5'd0)
                          && busy_q[bus.chk_addr1];
    assign bus.chk_busy2  = (bus.chk_addr2 != 5'd0)
                          && busy_q[bus.chk_addr2];

    // Address 0 is never written, whichever side holds the port.
    always_comb begin
        bus.rf_wr   = 1'b0;
        bus.rf_addr = 5'd0;
        bus.rf_data = 32'd0;
        if (pop) begin
            bus.rf_wr   = (head_addr != 5'd0);
            bus.rf_addr = head_addr;
            bus.rf_data = head_data;
        end else if (grant_wb) begin
            bus.rf_wr   = (bus.wb_addr != 5'd0);
            bus.rf_addr = bus.wb_addr;
            bus.rf_data = bus.wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase

        rd_d = rd_q;
        if (pop)
            rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
        wr_d = wr_q;
        if (push)
            wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;

        starve_d = starve_q;
        if (empty || pop)
            starve_d = 4'd0;
        else if (starve_q < LIM)
            starve_d = starve_q + 4'd1;

        // Clear first so a same-cycle issue to that register wins.
        busy_d = busy_q;
        if (pop)
            busy_d[head_addr] = 1'b0;
        if (bus.mdu_issue && bus.mdu_issue_addr != 5'd0)
            busy_d[bus.mdu_issue_addr] = 1'b1;
        busy_d[0] = 1'b0;

        perr_d = perr_q;
        if (bus.mdu_issue && busy_q[bus.mdu_issue_addr])
            perr_d = 1'b1;
        if (push && bus.mdu_addr != 5'd0 && !busy_q[bus.mdu_addr])
            perr_d = 1'b1;
        if (grant_wb && bus.wb_addr != 5'd0 && busy_q[bus.wb_addr])
            perr_d = 1'b1;
        if (bus.mdu_valid && !ready)
            perr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= 3'd0;
            starve_q <= 4'd0;
            busy_q   <= 32'd0;
            perr_q   <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_q] <= bus.mdu_addr;
            data_q[wr_q] <= bus.mdu_data;
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter with
// DEPTH=2 and STARVE_LIMIT=4.
module tb_rf_wport_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    rf_wport_arbiter_if bus ();

    rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_wr          = 1'b0;
        bus.wb_addr        = 5'd0;
        bus.wb_data        = 32'd0;
        bus.mdu_issue      = 1'b0;
        bus.mdu_issue_addr = 5'd0;
        bus.mdu_valid      = 1'b0;
        bus.mdu_addr       = 5'd0;
        bus.mdu_data       = 32'd0;
        bus.chk_addr1      = 5'd0;
        bus.chk_addr2      = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        bus.chk_addr1 = 5'd3;
        bus.chk_addr2 = 5'd31;
        #1;
        n_chk++;
        if (bus.fifo_count !== 3'd0) begin
            $display("FAIL rst_count act=%0d exp=0", bus.fifo_count);
            n_fail++;
        end
        n_chk++;
        if (bus.mdu_ready !== 1'b1) begin
            $display("FAIL rst_ready act=%b exp=1", bus.mdu_ready);
            n_fail++;
        end
        n_chk++;
        if (bus.rf_wr !== 1'b0 || bus.wb_stall !== 1'b0) begin
            $display("FAIL rst_wr act=%b/%b exp=0/0",
                     bus.rf_wr, bus.wb_stall);
            n_fail++;
        end
        n_chk++;
        if (bus.chk_busy1 !== 1'b0 || bus.chk_busy2 !== 1'b0 ||
            bus.proto_err !== 1'b0) begin
            $display("FAIL rst_busy act=%b%b%b exp=000",
                     bus.chk_busy1, bus.chk_busy2, bus.proto_err);
            n_fail++;
        end
    endtask

    task automatic test_wb_direct();
        bus.wb_wr   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h1234;
        #1;
        n_chk++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd5 ||
            bus.rf_data !== 32'h1234 || bus.wb_stall !== 1'b0) begin
            $display("FAIL wb_direct act=%b %0d %h %b exp=1 5 1234 0",
                     bus.rf_wr, bus.rf_addr, bus.rf_data, bus.wb_stall);
            n_fail++;
        end
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd10;
        cyc();
        bus.mdu_issue = 1'b0;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd10;
        bus.mdu_data  = 32'hAAAA;
        cyc();
        bus.mdu_valid = 1'b0;
        #1;
        n_chk++;
        if (bus.fifo_count !== 3'd1) begin
            $display("FAIL mid_pre_count act=%0d exp=1", bus.fifo_count);
            n_fail++;
        end
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.chk_addr1 = 5'd10;
        #1;
        n_chk++;
        if (bus.fifo_count !== 3'd0 || bus.rf_wr !== 1'b0 ||
            bus.chk_busy1 !== 1'b0) begin
            $display("FAIL mid_reset act=%0d %b %b exp=0 0 0",
                     bus.fifo_count, bus.rf_wr, bus.chk_busy1);
            n_fail++;
        end
    endtask

    task automatic test_mdu_basic();
        idle();
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd7;
        #1;
        n_chk++;
        if (bus.issue_ok !== 1'b1) begin
            $display("FAIL issue_ok_free act=%b exp=1", bus.issue_ok);
            n_fail++;
        end
        cyc();
        bus.mdu_issue = 1'b0;
        bus.chk_addr1 = 5'd7;
        #1;
        n_chk++;
        if (bus.chk_busy1 !== 1'b1 || bus.issue_ok !== 1'b0) begin
            $display("FAIL busy_set act=%b %b exp=1 0",
                     bus.chk_busy1, bus.issue_ok);
            n_fail++;
        end
        bus.mdu_issue_addr = 5'd0;
        bus.mdu_valid      = 1'b1;
        bus.mdu_addr       = 5'd7;
        bus.mdu_data       = 32'hDEAD;
        #1;
        n_chk++;
        if (bus.rf_wr !== 1'b0) begin
            $display("FAIL no_bypass act=%b exp=0", bus.rf_wr);
            n_fail++;
        end
        cyc();
        bus.mdu_valid = 1'b0;
        #1;
        n_chk++;
        if (bus.fifo_count !== 3'd1 || bus.rf_wr !== 1'b1 ||
            bus.rf_addr !== 5'd7 || bus.rf_data !== 32'hDEAD ||
            bus.chk_busy1 !== 1'b1) begin
            $display("FAIL mdu_write act=%0d %b %0d %h %b exp=1 1 7 dead 1",
                     bus.fifo_count, bus.rf_wr, bus.rf_addr,
                     bus.rf_data, bus.chk_busy1);
            n_fail++;
        end
        cyc();
        n_chk++;
        if (bus.fifo_count !== 3'd0 || bus.chk_busy1 !== 1'b0 ||
            bus.rf_wr !== 1'b0 || bus.proto_err !== 1'b0) begin
            $display("FAIL mdu_done act=%0d %b %b %b exp=0 0 0 0",
                     bus.fifo_count, bus.chk_busy1, bus.rf_wr,
                     bus.proto_err);
            n_fail++;
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd8;
        cyc();
        bus.mdu_issue_addr = 5'd9;
        cyc();
        bus.mdu_issue = 1'b0;
        bus.wb_wr     = 1'b1;
        bus.wb_addr   = 5'd20;
        bus.wb_data   = 32'h1;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd8;
        bus.mdu_data  = 32'h8;
        cyc();
        bus.wb_addr  = 5'd21;
        bus.mdu_addr = 5'd9;
        bus.mdu_data = 32'h9;
        cyc();
        bus.mdu_data = 32'h99;
        #1;
        n_chk++;
        if (bus.mdu_ready !== 1'b0 || bus.fifo_count !== 3'd2 ||
            bus.proto_err !== 1'b0) begin
            $display("FAIL full act=%b %0d %b exp=0 2 0",
                     bus.mdu_ready, bus.fifo_count, bus.proto_err);
            n_fail++;
        end
        cyc();
        bus.mdu_valid = 1'b0;
        bus.wb_wr     = 1'b0;
        #1;
        n_chk++;
        if (bus.proto_err !== 1'b1 || bus.fifo_count !== 3'd2) begin
            $display("FAIL overflow act=%b %0d exp=1 2",
                     bus.proto_err, bus.fifo_count);
            n_fail++;
        end
        n_chk++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd8 ||
            bus.rf_data !== 32'h8) begin
            $display("FAIL drain0 act=%b %0d %h exp=1 8 8",
                     bus.rf_wr, bus.rf_addr, bus.rf_data);
            n_fail++;
        end
        cyc();
        n_chk++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd9 ||
            bus.rf_data !== 32'h9) begin
            $display("FAIL drain1 act=%b %0d %h exp=1 9 9",
                     bus.rf_wr, bus.rf_addr, bus.rf_data);
            n_fail++;
        end
        cyc();
        n_chk++;
        if (bus.fifo_count !== 3'd0 || bus.rf_wr !== 1'b0) begin
            $display("FAIL drained act=%0d %b exp=0 0",
                     bus.fifo_count, bus.rf_wr);
            n_fail++;
        end
    endtask

    task automatic test_starve();
        do_reset();
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd12;
        cyc();
        bus.mdu_issue = 1'b0;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd12;
        bus.mdu_data  = 32'hC;
        bus.wb_wr     = 1'b1;
        bus.wb_addr   = 5'd1;
        bus.wb_data   = 32'h100;
        cyc();
        bus.mdu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (bus.wb_stall !== 1'b0 || bus.rf_addr !== 5'd1 ||
                bus.rf_data !== 32'h100) begin
                $display("FAIL starve_wait%0d act=%b %0d %h exp=0 1 100",
                         i, bus.wb_stall, bus.rf_addr, bus.rf_data);
                n_fail++;
            end
            cyc();
        end
        #1;
        n_chk++;
        if (bus.wb_stall !== 1'b1 || bus.rf_wr !== 1'b1 ||
            bus.rf_addr !== 5'd12 || bus.rf_data !== 32'hC) begin
            $display("FAIL starve_force act=%b %b %0d %h exp=1 1 12 c",
                     bus.wb_stall, bus.rf_wr, bus.rf_addr, bus.rf_data);
            n_fail++;
        end
        cyc();
        n_chk++;
        if (bus.wb_stall !== 1'b0 || bus.rf_addr !== 5'd1 ||
            bus.rf_data !== 32'h100 || bus.fifo_count !== 3'd0) begin
            $display("FAIL starve_after act=%b %0d %h %0d exp=0 1 100 0",
                     bus.wb_stall, bus.rf_addr, bus.rf_data,
                     bus.fifo_count);
            n_fail++;
        end
        bus.wb_wr = 1'b0;
        cyc();
        n_chk++;
        if (bus.proto_err !== 1'b0) begin
            $display("FAIL starve_perr act=%b exp=0", bus.proto_err);
            n_fail++;
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd3;
        cyc();
        bus.mdu_issue = 1'b0;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd3;
        bus.mdu_data  = 32'h33;
        cyc();
        bus.mdu_valid = 1'b0;
        bus.mdu_issue = 1'b1;
        bus.chk_addr2 = 5'd3;
        #1;
        n_chk++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd3) begin
            $display("FAIL sw_drain act=%b %0d exp=1 3",
                     bus.rf_wr, bus.rf_addr);
            n_fail++;
        end
        cyc();
        bus.mdu_issue = 1'b0;
        #1;
        n_chk++;
        if (bus.chk_busy2 !== 1'b1 || bus.proto_err !== 1'b1) begin
            $display("FAIL set_wins act=%b %b exp=1 1",
                     bus.chk_busy2, bus.proto_err);
            n_fail++;
        end
        do_reset();
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd3;
        cyc();
        bus.mdu_issue = 1'b0;
        bus.wb_wr     = 1'b1;
        bus.wb_addr   = 5'd3;
        bus.wb_data   = 32'h77;
        #1;
        n_chk++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd3 ||
            bus.rf_data !== 32'h77 || bus.proto_err !== 1'b0) begin
            $display("FAIL waw_write act=%b %0d %h %b exp=1 3 77 0",
                     bus.rf_wr, bus.rf_addr, bus.rf_data, bus.proto_err);
            n_fail++;
        end
        cyc();
        bus.wb_wr = 1'b0;
        #1;
        n_chk++;
        if (bus.proto_err !== 1'b1) begin
            $display("FAIL waw_perr act=%b exp=1", bus.proto_err);
            n_fail++;
        end
    endtask

    task automatic test_addr0();
        do_reset();
        bus.mdu_issue      = 1'b1;
        bus.mdu_issue_addr = 5'd0;
        #1;
        n_chk++;
        if (bus.issue_ok !== 1'b1) begin
            $display("FAIL a0_issue_ok act=%b exp=1", bus.issue_ok);
            n_fail++;
        end
        cyc();
        bus.mdu_issue = 1'b0;
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = 5'd0;
        bus.mdu_data  = 32'h5;
        bus.wb_wr     = 1'b1;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'h6;
        #1;
        n_chk++;
        if (bus.rf_wr !== 1'b0 || bus.wb_stall !== 1'b0) begin
            $display("FAIL a0_wb act=%b %b exp=0 0",
                     bus.rf_wr, bus.wb_stall);
            n_fail++;
        end
        cyc();
        idle();
        #1;
        n_chk++;
        if (bus.fifo_count !== 3'd1 || bus.rf_wr !== 1'b0) begin
            $display("FAIL a0_head act=%0d %b exp=1 0",
                     bus.fifo_count, bus.rf_wr);
            n_fail++;
        end
        cyc();
        n_chk++;
        if (bus.fifo_count !== 3'd0 || bus.proto_err !== 1'b0 ||
            bus.chk_busy1 !== 1'b0 || bus.issue_ok !== 1'b1) begin
            $display("FAIL a0_done act=%0d %b %b %b exp=0 0 0 1",
                     bus.fifo_count, bus.proto_err, bus.chk_busy1,
                     bus.issue_ok);
            n_fail++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_wb_direct();
        test_mdu_basic();
        test_fifo_full();
        test_starve();
        test_set_wins();
        test_addr0();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
